// File: rtl/calc_requester.sv
// calc_requester: FIFO-buffered initiator for a combinational 8-bit calculator; returns results in order.
// Build option: define CALC_REQ_TAG_EN to carry a TAG_W-bit tag from cmd_tag through to rsp_tag.
module calc_requester #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_a,
  input  logic [7:0]        cmd_b,
  input  logic [1:0]        cmd_op,
`ifdef CALC_REQ_TAG_EN
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic [TAG_W-1:0]  rsp_tag,
`endif
  output logic [7:0]        calc_first_num,
  output logic [7:0]        calc_second_num,
  output logic [1:0]        calc_operation,
  input  logic [15:0]       calc_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [15:0]       rsp_result,
  output logic              rsp_err
);

`ifdef CALC_REQ_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif
  localparam int TAG_BITS = TAG_EN ? TAG_W : 0;
  localparam int CMD_W    = 18;
  localparam int ENTRY_W  = CMD_W + TAG_BITS;
  localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]         first_q, first_d;
  logic [7:0]         second_q, second_d;
  logic [1:0]         op_q, op_d;
  logic               div0_q, div0_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [15:0]        rsp_result_q, rsp_result_d;
  logic               rsp_err_q, rsp_err_d;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic [7:0]         head_a;
  logic [7:0]         head_b;
  logic [1:0]         head_op;
  logic               fifo_empty;
  logic               push;
  logic               pop;

  // Entry layout: {tag (optional), a, b, op}
`ifdef CALC_REQ_TAG_EN
  logic [TAG_W-1:0]   head_tag;
  logic [TAG_W-1:0]   cur_tag_q, cur_tag_d;
  logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
  assign wr_entry = {cmd_tag, cmd_a, cmd_b, cmd_op};
  assign head_tag = head_entry[ENTRY_W-1:CMD_W];
`else
  assign wr_entry = {cmd_a, cmd_b, cmd_op};
`endif

  assign head_entry = mem_q[rd_ptr_q];
  assign head_a     = head_entry[17:10];
  assign head_b     = head_entry[9:2];
  assign head_op    = head_entry[1:0];

  assign fifo_empty = (count_q == '0);
  assign cmd_ready  = (count_q != (PTR_W+1)'(DEPTH));
  assign push       = cmd_valid & cmd_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    first_d      = first_q;
    second_d     = second_q;
    op_d         = op_q;
    div0_d       = div0_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
`ifdef CALC_REQ_TAG_EN
    cur_tag_d    = cur_tag_q;
    rsp_tag_d    = rsp_tag_q;
`endif

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        state_d      = RESP;
        rsp_valid_d  = 1'b1;
        rsp_result_d = div0_q ? 16'hFFFF : calc_result;
        rsp_err_d    = div0_q;
`ifdef CALC_REQ_TAG_EN
        rsp_tag_d    = cur_tag_q;
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = DRIVE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The calculator computes second-first, so swap operands to present A-B.
    if (pop) begin
      if (head_op == OP_SUB) begin
        first_d  = head_b;
        second_d = head_a;
      end else begin
        first_d  = head_a;
        second_d = head_b;
      end
      op_d   = head_op;
      div0_d = (head_op == OP_DIV) && (head_b == 8'd0);
`ifdef CALC_REQ_TAG_EN
      cur_tag_d = head_tag;
`endif
    end
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + (PTR_W+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      first_q      <= '0;
      second_q     <= '0;
      op_q         <= '0;
      div0_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
`ifdef CALC_REQ_TAG_EN
      cur_tag_q    <= '0;
      rsp_tag_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      first_q      <= first_d;
      second_q     <= second_d;
      op_q         <= op_d;
      div0_q       <= div0_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
`ifdef CALC_REQ_TAG_EN
      cur_tag_q    <= cur_tag_d;
      rsp_tag_q    <= rsp_tag_d;
`endif
    end
  end

  assign calc_first_num  = first_q;
  assign calc_second_num = second_q;
  assign calc_operation  = op_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_result      = rsp_result_q;
  assign rsp_err         = rsp_err_q;
`ifdef CALC_REQ_TAG_EN
  assign rsp_tag         = rsp_tag_q;
`endif

endmodule

// File: tb/tb_calc_requester.sv
// Directed testbench for calc_requester with a behavioural calculator model (second-first subtract).
`timescale 1ns/1ps
module tb_calc_requester;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [1:0]  cmd_op;
  logic [7:0]  calc_first_num;
  logic [7:0]  calc_second_num;
  logic [1:0]  calc_operation;
  logic [15:0] calc_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_err;
`ifdef CALC_REQ_TAG_EN
  logic [3:0]  cmd_tag;
  logic [3:0]  rsp_tag;
`endif

  int checks = 0;
  int errors = 0;

  calc_requester #(.DEPTH(4), .TAG_W(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_a           (cmd_a),
    .cmd_b           (cmd_b),
    .cmd_op          (cmd_op),
`ifdef CALC_REQ_TAG_EN
    .cmd_tag         (cmd_tag),
    .rsp_tag         (rsp_tag),
`endif
    .calc_first_num  (calc_first_num),
    .calc_second_num (calc_second_num),
    .calc_operation  (calc_operation),
    .calc_result     (calc_result),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_result      (rsp_result),
    .rsp_err         (rsp_err)
  );

  always #5 clk = ~clk;

  // Calculator: subtract is second-first; divide-by-zero returns junk the DUT must hide.
  always_comb begin
    calc_result = 16'h0000;
    case (calc_operation)
      2'b00: calc_result = {8'd0, calc_first_num} + {8'd0, calc_second_num};
      2'b01: calc_result = {8'd0, calc_second_num} - {8'd0, calc_first_num};
      2'b10: calc_result = {8'd0, calc_first_num} * {8'd0, calc_second_num};
      default: calc_result = (calc_second_num == 8'd0) ? 16'h5A5A
                                                       : {8'd0, calc_first_num / calc_second_num};
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns 1ns after the edge at which the command was accepted.
  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    int waited;
    waited = 0;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    cmd_valid = 1'b1;
    while (!cmd_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (waited >= 50) check("push_timeout", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic single(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] op, input logic [7:0] f, input logic [7:0] s,
                        input logic [15:0] res, input logic err);
    push(a, b, op);
    tick();
    check({name, "_first"}, 32'(calc_first_num), 32'(f));
    check({name, "_second"}, 32'(calc_second_num), 32'(s));
    check({name, "_op"}, 32'(calc_operation), 32'(op));
    check({name, "_valid_early"}, 32'(rsp_valid), 32'd0);
    tick();
    check({name, "_valid"}, 32'(rsp_valid), 32'd1);
    check({name, "_result"}, 32'(rsp_result), 32'(res));
    check({name, "_err"}, 32'(rsp_err), 32'(err));
    $display("txn %s: a=%0d b=%0d op=%0d -> result=%h err=%0d", name, a, b, op, rsp_result, rsp_err);
    tick();
    check({name, "_valid_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  logic [7:0]  t4_a   [5] = '{8'd10, 8'd9, 8'd16, 8'd100, 8'd1};
  logic [7:0]  t4_b   [5] = '{8'd20, 8'd4, 8'd16, 8'd7, 8'd2};
  logic [1:0]  t4_op  [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01};
  logic [15:0] t4_exp [5] = '{16'h001E, 16'h0005, 16'h0100, 16'h000E, 16'hFFFF};

  initial begin
    int got;
    int cyc;
    int last;
    int seen;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_a = 8'd0;
    cmd_b = 8'd0;
    cmd_op = 2'b00;
    rsp_ready = 1'b1;
`ifdef CALC_REQ_TAG_EN
    cmd_tag = 4'h0;
`endif
    tick();
    tick();
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_result", 32'(rsp_result), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_calc_first", 32'(calc_first_num), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    rst = 1'b0;
    tick();
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Single-command latency and operand mapping
    single("t1_add", 8'd200, 8'd100, 2'b00, 8'd200, 8'd100, 16'd300, 1'b0);
    single("t2_sub_neg", 8'd3, 8'd5, 2'b01, 8'd5, 8'd3, 16'hFFFE, 1'b0);
    single("t2_sub_pos", 8'd5, 8'd3, 2'b01, 8'd3, 8'd5, 16'h0002, 1'b0);
    single("t3_mul", 8'd255, 8'd255, 2'b10, 8'd255, 8'd255, 16'hFE01, 1'b0);
    single("t3_div0", 8'd7, 8'd0, 2'b11, 8'd7, 8'd0, 16'hFFFF, 1'b1);
    single("t3_div", 8'd200, 8'd7, 2'b11, 8'd200, 8'd7, 16'h001C, 1'b0);

    // Backpressure: one command held in RESP plus a full FIFO
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(t4_a[i], t4_b[i], t4_op[i]);
    check("t4_full_ready", 32'(cmd_ready), 32'd0);
    check("t4_head_valid", 32'(rsp_valid), 32'd1);
    check("t4_head_result", 32'(rsp_result), 32'(t4_exp[0]));
    tick();
    tick();
    check("t4_hold_valid", 32'(rsp_valid), 32'd1);
    check("t4_hold_result", 32'(rsp_result), 32'(t4_exp[0]));
    rsp_ready = 1'b1;
    got = 0;
    cyc = 0;
    last = 0;
    while (got < 5 && cyc < 40) begin
      if (rsp_valid) begin
        check($sformatf("t4_result%0d", got), 32'(rsp_result), 32'(t4_exp[got]));
        check($sformatf("t4_err%0d", got), 32'(rsp_err), 32'd0);
        if (got > 0) check($sformatf("t4_gap%0d", got), 32'(cyc - last), 32'd2);
        $display("txn t4 rsp%0d: result=%h at cycle %0d", got, rsp_result, cyc);
        last = cyc;
        got++;
      end
      tick();
      cyc++;
    end
    check("t4_count", 32'(got), 32'd5);
    check("t4_idle_valid", 32'(rsp_valid), 32'd0);

    // Reset while the second command is in DRIVE with three still queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(t4_a[i], t4_b[i], t4_op[i]);
    rsp_ready = 1'b1;
    tick();
    check("t5_drive_first", 32'(calc_first_num), 32'd4);
    check("t5_drive_second", 32'(calc_second_num), 32'd9);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_valid", 32'(rsp_valid), 32'd0);
    check("t5_rst_first", 32'(calc_first_num), 32'd0);
    check("t5_rst_ready", 32'(cmd_ready), 32'd1);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("t5_ready_first_edge", 32'(cmd_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid || calc_first_num != 8'd0) seen++;
      tick();
    end
    check("t5_no_stale_activity", 32'(seen), 32'd0);
    $display("txn t5: reset mid-operation, stale activity count=%0d", seen);
    single("t5_after", 8'd128, 8'd128, 2'b00, 8'd128, 8'd128, 16'h0100, 1'b0);

`ifdef CALC_REQ_TAG_EN
    rsp_ready = 1'b0;
    cmd_tag = 4'h3;
    push(8'd1, 8'd1, 2'b00);
    cmd_tag = 4'hA;
    push(8'd2, 8'd2, 2'b00);
    tick();
    check("t6_valid0", 32'(rsp_valid), 32'd1);
    check("t6_tag0", 32'(rsp_tag), 32'h3);
    check("t6_res0", 32'(rsp_result), 32'd2);
    rsp_ready = 1'b1;
    tick();
    tick();
    check("t6_valid1", 32'(rsp_valid), 32'd1);
    check("t6_tag1", 32'(rsp_tag), 32'hA);
    check("t6_res1", 32'(rsp_result), 32'd4);
    $display("txn t6: tags returned in order");
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
